pc_redirect_ctrl: RTL and testbench

PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

---
 rtl/pc_redirect_ctrl_pkg.sv | 27 ++
 rtl/pc_redirect_ctrl_if.sv | 33 +++
 rtl/pc_redirect_ctrl_arb.sv | 34 +++
 rtl/pc_redirect_ctrl.sv | 123 ++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pc_redirect_ctrl_pkg.sv
// Shared types and defaults for the PC redirect controller.
// Redirect kinds are encoded so that a larger value means higher priority.
package pc_ctrl_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC   = 32'h0000_0000;
    localparam int unsigned DEFAULT_INSN_BYTES = 4;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_BR   = 2'd1,
        KIND_ISR  = 2'd2,
        KIND_RET  = 2'd3
    } redir_kind_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    typedef struct packed {
        redir_kind_e kind;
        logic [31:0] target;
    } redir_t;

    localparam redir_t REDIR_NONE = '{kind: KIND_NONE, target: 32'h0};

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Fetch-side bundle between the pipeline (master) and the PC redirect controller (slave).
interface pc_redirect_ctrl_if;

    logic [31:0] pc_cur;
    logic        im_stall;
    logic        dm_stall;
    logic        csr_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        csr_ret;
    logic [31:0] csr_retpc;
    logic        csr_interrupt;
    logic [31:0] csr_isr_pc;
    logic        csr_reset;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        flush;
    logic        isr_ack;
    logic        redirect_pending;

    modport master (
        output pc_cur, im_stall, dm_stall, csr_stall, br_taken, br_target,
               csr_ret, csr_retpc, csr_interrupt, csr_isr_pc, csr_reset,
        input  pc_next, pc_we, flush, isr_ack, redirect_pending
    );

    modport slave (
        input  pc_cur, im_stall, dm_stall, csr_stall, br_taken, br_target,
               csr_ret, csr_retpc, csr_interrupt, csr_isr_pc, csr_reset,
        output pc_next, pc_we, flush, isr_ack, redirect_pending
    );

endinterface

// File: rtl/pc_redirect_ctrl_arb.sv
// Priority arbiter: picks the highest live redirect source, then merges it
// with the pending redirect (pending wins ties).
module pc_redirect_arb
    import pc_ctrl_pkg::*;
(
    input  logic        csr_ret_i,
    input  logic [31:0] csr_retpc_i,
    input  logic        irq_edge_i,
    input  logic [31:0] csr_isr_pc_i,
    input  logic        br_taken_i,
    input  logic [31:0] br_target_i,
    input  redir_t      pend_i,
    output redir_t      live_o,
    output redir_t      win_o
);

    redir_t live;

    // NOTE: default assignment first so every path drives live and no latch is inferred.
    always_comb begin
        live = REDIR_NONE;
        if (csr_ret_i) begin
            live = '{kind: KIND_RET, target: csr_retpc_i};
        end else if (irq_edge_i) begin
            live = '{kind: KIND_ISR, target: csr_isr_pc_i};
        end else if (br_taken_i) begin
            live = '{kind: KIND_BR, target: br_target_i};
        end
    end

    assign live_o = live;
    assign win_o  = (live.kind > pend_i.kind) ? live : pend_i;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC next-value selection with stall-tolerant redirect holding.
// Optional redirect counter port enabled by `define PC_REDIRECT_CNT_EN.
module pc_redirect_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned INSN_BYTES = DEFAULT_INSN_BYTES
) (
    input  logic clk,
    input  logic reset,
    pc_redirect_ctrl_if.slave bus
`ifdef PC_REDIRECT_CNT_EN
    ,
    output logic [15:0] redirect_cnt
`endif
);

    state_e state_q, state_d;
    redir_t pend_q, pend_d;
    logic   irq_q;
    logic   irq_edge;
    logic   stall;
    redir_t live;
    redir_t win;

    assign stall    = bus.im_stall | bus.dm_stall | bus.csr_stall;
    assign irq_edge = bus.csr_interrupt & ~irq_q;

    pc_redirect_arb u_arb (
        .csr_ret_i    (bus.csr_ret),
        .csr_retpc_i  (bus.csr_retpc),
        .irq_edge_i   (irq_edge),
        .csr_isr_pc_i (bus.csr_isr_pc),
        .br_taken_i   (bus.br_taken),
        .br_target_i  (bus.br_target),
        .pend_i       (pend_q),
        .live_o       (live),
        .win_o        (win)
    );

    always_comb begin
        bus.pc_next = bus.pc_cur + 32'(INSN_BYTES);
        bus.pc_we   = 1'b0;
        bus.flush   = 1'b0;
        bus.isr_ack = 1'b0;
        state_d     = state_q;
        pend_d      = pend_q;

        if (reset || bus.csr_reset) begin
            // Soft reset overrides stall and discards anything pending.
            bus.pc_next = RESET_PC;
            bus.pc_we   = 1'b1;
            bus.flush   = 1'b1;
            state_d     = ST_RUN;
            pend_d      = REDIR_NONE;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!stall) begin
                        bus.pc_we = 1'b1;
                        if (win.kind != KIND_NONE) begin
                            bus.pc_next = win.target;
                            bus.flush   = 1'b1;
                            bus.isr_ack = (win.kind == KIND_ISR);
                        end
                    end else if (live.kind != KIND_NONE) begin
                        pend_d  = live;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (stall) begin
                        if (live.kind > pend_q.kind) begin
                            pend_d = live;
                        end
                    end else begin
                        bus.pc_next = win.target;
                        bus.pc_we   = 1'b1;
                        bus.flush   = 1'b1;
                        bus.isr_ack = (win.kind == KIND_ISR);
                        state_d     = ST_RUN;
                        pend_d      = REDIR_NONE;
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    pend_d  = REDIR_NONE;
                end
            endcase
        end
    end

    // Gated so a reset landing mid-HOLD reports nothing pending immediately.
    assign bus.redirect_pending = (state_q == ST_HOLD) & ~reset;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pend_q  <= REDIR_NONE;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            irq_q   <= bus.csr_interrupt;
        end
    end

`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 16'h0;
        end else if (bus.pc_we && bus.flush && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'h1;
        end
    end

    assign redirect_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Directed testbench for pc_redirect_ctrl with hand-computed expectations.
module tb_pc_redirect_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    int   acks;

    always #5 clk = ~clk;

    pc_redirect_ctrl_if bus ();

`ifdef PC_REDIRECT_CNT_EN
    logic [15:0] redirect_cnt;
`endif

    pc_redirect_ctrl #(
        .RESET_PC   (RST_PC),
        .INSN_BYTES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef PC_REDIRECT_CNT_EN
        ,
        .redirect_cnt (redirect_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [31:0] nxt, input logic we,
                             input logic fl, input logic ack, input logic pend);
        check({tag, ".pc_next"}, bus.pc_next, nxt);
        check({tag, ".pc_we"}, 32'(bus.pc_we), 32'(we));
        check({tag, ".flush"}, 32'(bus.flush), 32'(fl));
        check({tag, ".isr_ack"}, 32'(bus.isr_ack), 32'(ack));
        check({tag, ".pending"}, 32'(bus.redirect_pending), 32'(pend));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle();
        bus.pc_cur        = 32'h0;
        bus.im_stall      = 1'b0;
        bus.dm_stall      = 1'b0;
        bus.csr_stall     = 1'b0;
        bus.br_taken      = 1'b0;
        bus.br_target     = 32'h0;
        bus.csr_ret       = 1'b0;
        bus.csr_retpc     = 32'h0;
        bus.csr_interrupt = 1'b0;
        bus.csr_isr_pc    = 32'h0;
        bus.csr_reset     = 1'b0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick(); settle();
        check_out("reset", RST_PC, 1, 1, 0, 0);
        tick();
        reset = 1'b0;

        // Sequential fetch
        for (int i = 0; i < 3; i++) begin
            bus.pc_cur = 32'(i * 4);
            settle();
            check_out("seq", 32'(i * 4 + 4), 1, 0, 0, 0);
            tick();
        end

        // Branch held through a 3-cycle data stall
        bus.pc_cur = 32'h10; bus.br_taken = 1; bus.br_target = 32'h100; bus.dm_stall = 1;
        settle();
        check("br_stall0.pc_we", 32'(bus.pc_we), 0);
        check("br_stall0.flush", 32'(bus.flush), 0);
        tick();
        bus.br_taken = 0;
        for (int i = 0; i < 2; i++) begin
            settle();
            check("br_hold.pc_we", 32'(bus.pc_we), 0);
            check("br_hold.pending", 32'(bus.redirect_pending), 1);
            tick();
        end
        bus.dm_stall = 0;
        settle();
        check_out("br_release", 32'h100, 1, 1, 0, 1);
        tick();
        bus.pc_cur = 32'h100;
        settle();
        check_out("br_after", 32'h104, 1, 0, 0, 0);
        tick();

        // Interrupt edge during HOLD outranks pending branch
        bus.br_taken = 1; bus.br_target = 32'h100; bus.dm_stall = 1;
        tick();
        bus.br_taken = 0; bus.csr_interrupt = 1; bus.csr_isr_pc = 32'h200;
        settle();
        check("irq_hold.pc_we", 32'(bus.pc_we), 0);
        tick();
        settle();
        check("irq_hold2.pending", 32'(bus.redirect_pending), 1);
        tick();
        bus.dm_stall = 0;
        settle();
        check_out("irq_release", 32'h200, 1, 1, 1, 1);
        tick();
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            bus.pc_cur = 32'h200 + 32'(i * 4);
            settle();
            acks += int'(bus.isr_ack);
            tick();
        end
        check("irq_level_noretrigger", 32'(acks), 0);
        bus.csr_interrupt = 0;
        tick();

        // Unstalled interrupt edge applies immediately
        bus.csr_interrupt = 1; bus.csr_isr_pc = 32'h280; bus.pc_cur = 32'h300;
        settle();
        check_out("irq_direct", 32'h280, 1, 1, 1, 0);
        tick();
        bus.csr_interrupt = 0;
        tick();

        // Return beats interrupt edge and branch in the same cycle
        bus.csr_interrupt = 1; bus.csr_isr_pc = 32'h200;
        bus.csr_ret = 1; bus.csr_retpc = 32'h40;
        bus.br_taken = 1; bus.br_target = 32'h300; bus.pc_cur = 32'h400;
        settle();
        check_out("ret_prio", 32'h40, 1, 1, 0, 0);
        tick();
        bus.csr_ret = 0; bus.br_taken = 0; bus.pc_cur = 32'h40;
        settle();
        check_out("ret_after", 32'h44, 1, 0, 0, 0);
        tick();
        bus.csr_interrupt = 0;
        tick();

        // HOLD: higher priority overwrites, lower dropped, same-cycle lower loses at release
        bus.dm_stall = 1; bus.br_taken = 1; bus.br_target = 32'h100; bus.pc_cur = 32'h500;
        tick();
        bus.br_taken = 0; bus.csr_ret = 1; bus.csr_retpc = 32'h40;
        tick();
        bus.csr_ret = 0; bus.br_taken = 1; bus.br_target = 32'h500;
        tick();
        bus.dm_stall = 0; bus.br_target = 32'h600;
        settle();
        check_out("hold_overwrite", 32'h40, 1, 1, 0, 1);
        tick();

        // Tie at release: pending branch beats same-cycle branch
        bus.dm_stall = 1; bus.br_target = 32'h100;
        tick();
        bus.br_taken = 0;
        tick();
        bus.dm_stall = 0; bus.br_taken = 1; bus.br_target = 32'h700;
        settle();
        check("hold_tie.pc_next", bus.pc_next, 32'h100);
        tick();
        bus.br_taken = 0;

        // Soft reset during HOLD with instruction stall
        bus.im_stall = 1; bus.br_taken = 1; bus.br_target = 32'h100;
        tick();
        bus.br_taken = 0; bus.csr_reset = 1;
        settle();
        check_out("csr_reset", RST_PC, 1, 1, 0, 1);
        tick();
        bus.csr_reset = 0;
        settle();
        check("csr_reset_after.pc_we", 32'(bus.pc_we), 0);
        check("csr_reset_after.pending", 32'(bus.redirect_pending), 0);
        tick();
        bus.im_stall = 0; bus.pc_cur = RST_PC;
        settle();
        check_out("csr_reset_run", RST_PC + 32'h4, 1, 0, 0, 0);
        tick();

        // Hard reset mid-HOLD with a pending ISR discards it
        bus.csr_stall = 1; bus.csr_interrupt = 1; bus.csr_isr_pc = 32'h200;
        tick();
        settle();
        check("isr_hold.pending", 32'(bus.redirect_pending), 1);
        reset = 1; bus.csr_interrupt = 0; bus.csr_stall = 0;
        settle();
        check_out("reset_mid_hold", RST_PC, 1, 1, 0, 0);
        tick();
        reset = 0; bus.pc_cur = RST_PC;
        settle();
        check_out("after_reset", RST_PC + 32'h4, 1, 0, 0, 0);
        tick();

`ifdef PC_REDIRECT_CNT_EN
        check("cnt_after_reset", 32'(redirect_cnt), 0);
        for (int i = 0; i < 5; i++) begin
            bus.br_taken = 1; bus.br_target = 32'h800 + 32'(i * 16);
            tick();
        end
        bus.br_taken = 0;
        settle();
        check("cnt_five", 32'(redirect_cnt), 5);
        tick();
`endif

        // Sequential wrap at the top of the address space
        bus.pc_cur = 32'hFFFF_FFFC;
        settle();
        check_out("wrap", 32'h0, 1, 0, 0, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
